demux_8x1_4b_seq: RTL and testbench
===================================

Name: demux_8x1_4b_seq

Overview:
- Registered 1-to-8 demultiplexer/deserializer for 4-bit data; inverse of the 8x1 4-bit mux path.
- Each accepted input nibble is steered into one of eight held output lanes. The lane comes from an explicit select, or from an internal round-robin pointer in auto mode.
- Per-lane valid flags, a frame-complete pulse and an overrun pulse let downstream logic consume lanes with a simple handshake.
- Sits on the receive side of any path that serializes eight nibbles through the 8x1 mux.

Parameters:
- WIDTH, 4, bits per lane and per input nibble.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  data nibble.
- in_valid  input  1  in is valid this cycle; the nibble is accepted at the next rising edge.
- s  input  3  target lane in manual mode; ignored when auto_mode=1.
- auto_mode  input  1  1 = target lane is ptr, 0 = target lane is s.
- clear  input  1  synchronous: ptr<=0 and lane_valid<=0; lane data is kept.
- lane_clr  input  8  per-lane consume strobe; clears the matching lane_valid bits.
- o0..o7  output  WIDTH each  registered lane data.
- lane_valid  output  8  lane k holds unconsumed data.
- ptr  output  3  auto-mode write pointer.
- frame_done  output  1  one-cycle pulse.
- overrun  output  1  one-cycle pulse.

Behaviour:
- Reset: rst_n low asynchronously forces o0..o7=0, lane_valid=0, ptr=0, frame_done=0, overrun=0, at any point including mid-frame. No state survives reset.
- Target lane t = auto_mode ? ptr : s.
- Write enable is a one-hot decode of t, gated by in_valid & ~clear.
- Latency: in_valid at edge N updates o_t and sets lane_valid[t] at edge N; both are visible in cycle N+1.
- ptr:
  - Advances by 1 mod 8 on each accepted write while auto_mode=1; 7 wraps to 0.
  - Unchanged in manual mode.
  - Retained across auto_mode toggles, so a switch takes effect on the next accepted write.
- lane_valid[k] next-state priority:
  1. clear -> 0.
  2. Write to k -> 1. A write wins over a simultaneous lane_clr[k].
  3. lane_clr[k] -> 0.
  4. Otherwise hold.
- Lane data:
  - o_k changes only on a write to lane k.
  - clear and lane_clr never alter data.
- overrun: registered pulse, 1 for the cycle after a write to lane k whose lane_valid[k] was 1 and lane_clr[k] was 0 at that edge. The data is overwritten regardless.
- frame_done: registered pulse, 1 for the cycle after an edge at which lane_valid goes from not-all-ones to all-ones.
  - No pulse while lane_valid stays at 8'hFF, including during overwrites.
- clear with in_valid in the same cycle: clear wins, the write is dropped, and no overrun or frame_done pulse is generated.
- Width: all lanes are exactly WIDTH bits; there is no extension or truncation.

Decomposition:
- Shared package constants: LANES=8, SEL_W=3, DEFAULT_WIDTH=4.
- One natural sub-module: dec_3x8, a combinational 3-to-8 one-hot decoder with enable, used to generate the lane write enables.
- Lane registers, the pointer counter and the pulse logic remain in the top module.

Test Plan:
- Reset mid-frame: auto mode, 3 nibbles written, then assert rst_n=0 -> all outputs read 0 immediately, ptr=0.
- Auto frame: auto_mode=1, feed 4'h1..4'h8 on consecutive cycles -> o0..o7=1..8, ptr wraps to 0, frame_done pulses once one cycle after the 8th write, overrun never asserts.
- Manual writes: s=5 with in=4'hA -> o5=A and lane_valid=8'b0010_0000 next cycle. A second write to s=5 with in=4'hB and no lane_clr -> o5=B, overrun pulses for exactly 1 cycle.
- Write/consume collision: lane_valid[2]=1, then write to lane 2 with lane_clr=8'h04 in the same cycle -> lane_valid[2] stays 1, overrun=0. lane_clr=8'h04 alone next cycle -> lane_valid[2]=0, o2 unchanged.
- Clear priority: in_valid=1, clear=1, auto mode with ptr=3 -> no data change, ptr=0, lane_valid=0, no pulses.
- Mode switch: auto mode, write 2 nibbles (ptr=2), switch to manual with s=6 and write 4'hC -> o6=C, ptr stays 2. Switch back to auto and write 4'hD -> o2=D, ptr=3.

Source files
------------

// File: rtl/demux_8x1_4b_seq_pkg.sv
// Shared constants and helpers for the registered 1-to-8 nibble demultiplexer.
package demux_8x1_4b_seq_pkg;

    localparam int LANES         = 8;
    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 4;

    typedef logic [LANES-1:0] lane_mask_t;
    typedef logic [SEL_W-1:0] lane_sel_t;

    // Round-robin pointer step; the natural SEL_W-bit overflow gives the 7 -> 0 wrap.
    function automatic lane_sel_t ptr_inc(input lane_sel_t p);
        return p + lane_sel_t'(1);
    endfunction

endpackage

// File: rtl/demux_8x1_4b_seq_if.sv
// Bus bundle for the demultiplexer: nibble input side, held lanes and status pulses.
interface demux_8x1_4b_seq_if
    import demux_8x1_4b_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    lane_sel_t        s;
    logic             auto_mode;
    logic             clear;
    lane_mask_t       lane_clr;

    logic [WIDTH-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    lane_mask_t       lane_valid;
    lane_sel_t        ptr;
    logic             frame_done;
    logic             overrun;

    modport master (
        output in, in_valid, s, auto_mode, clear, lane_clr,
        input  o0, o1, o2, o3, o4, o5, o6, o7, lane_valid, ptr, frame_done, overrun
    );

    modport slave (
        input  in, in_valid, s, auto_mode, clear, lane_clr,
        output o0, o1, o2, o3, o4, o5, o6, o7, lane_valid, ptr, frame_done, overrun
    );
endinterface

// File: rtl/demux_8x1_4b_seq_dec_3x8.sv
// Combinational 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec_3x8
    import demux_8x1_4b_seq_pkg::*;
(
    input  lane_sel_t  sel,
    input  logic       en,
    output lane_mask_t onehot
);
    for (genvar gi = 0; gi < LANES; gi++) begin : g_dec
        assign onehot[gi] = en && (sel == lane_sel_t'(gi));
    end
endmodule

// File: rtl/demux_8x1_4b_seq.sv
// Registered 1-to-8 nibble demultiplexer with per-lane valid flags,
// round-robin auto mode, frame-complete and overrun pulses.
module demux_8x1_4b_seq
    import demux_8x1_4b_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input logic               clk,
    input logic               rst_n,
    demux_8x1_4b_seq_if.slave bus
);
    logic [WIDTH-1:0] lane_reg [LANES];
    lane_mask_t       lane_valid_reg, lane_valid_next;
    lane_sel_t        ptr_reg, ptr_next;
    logic             overrun_reg, overrun_next;
    logic             frame_done_reg, frame_done_next;

    lane_sel_t  target;
    logic       wr_en;
    lane_mask_t we;

    assign target = bus.auto_mode ? ptr_reg : bus.s;
    // clear suppresses the write entirely, so it can never raise overrun or frame_done.
    assign wr_en  = bus.in_valid && !bus.clear;

    dec_3x8 u_dec (
        .sel    (target),
        .en     (wr_en),
        .onehot (we)
    );

    always_comb begin
        ptr_next = ptr_reg;
        if (bus.clear)
            ptr_next = '0;
        else if (wr_en && bus.auto_mode)
            ptr_next = ptr_inc(ptr_reg);
    end

    always_comb begin
        lane_valid_next = lane_valid_reg;
        if (bus.clear)
            lane_valid_next = '0;
        else
            lane_valid_next = we | (lane_valid_reg & ~bus.lane_clr);
    end

    // A write into a still-valid lane is an overrun unless that lane is consumed at the same edge.
    assign overrun_next    = |(we & lane_valid_reg & ~bus.lane_clr);
    assign frame_done_next = (lane_valid_next == '1) && (lane_valid_reg != '1);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                lane_reg[gi] <= '0;
            else if (we[gi])
                lane_reg[gi] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid_reg <= '0;
            ptr_reg        <= '0;
            overrun_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            lane_valid_reg <= lane_valid_next;
            ptr_reg        <= ptr_next;
            overrun_reg    <= overrun_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.o0         = lane_reg[0];
    assign bus.o1         = lane_reg[1];
    assign bus.o2         = lane_reg[2];
    assign bus.o3         = lane_reg[3];
    assign bus.o4         = lane_reg[4];
    assign bus.o5         = lane_reg[5];
    assign bus.o6         = lane_reg[6];
    assign bus.o7         = lane_reg[7];
    assign bus.lane_valid = lane_valid_reg;
    assign bus.ptr        = ptr_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_demux_8x1_4b_seq.sv
// Directed self-checking bench for demux_8x1_4b_seq.
module tb_demux_8x1_4b_seq;
    logic clk;
    logic rst_n;
    int   checks_cnt;
    int   errors_cnt;

    demux_8x1_4b_seq_if #(.WIDTH(4)) bus ();

    demux_8x1_4b_seq #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] o_arr [8];
    always_comb begin
        o_arr[0] = bus.o0; o_arr[1] = bus.o1; o_arr[2] = bus.o2; o_arr[3] = bus.o3;
        o_arr[4] = bus.o4; o_arr[5] = bus.o5; o_arr[6] = bus.o6; o_arr[7] = bus.o7;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic am, input logic [2:0] sel, input logic [3:0] d,
                      input logic [7:0] lc, input logic clr);
        bus.auto_mode = am;
        bus.s         = sel;
        bus.in        = d;
        bus.in_valid  = 1'b1;
        bus.lane_clr  = lc;
        bus.clear     = clr;
        step();
        bus.in_valid  = 1'b0;
        bus.lane_clr  = 8'h00;
        bus.clear     = 1'b0;
    endtask

    task automatic idle(input logic [7:0] lc, input logic clr);
        bus.lane_clr = lc;
        bus.clear    = clr;
        step();
        bus.lane_clr = 8'h00;
        bus.clear    = 1'b0;
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        rst_n         = 1'b0;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.s         = '0;
        bus.auto_mode = 1'b0;
        bus.clear     = 1'b0;
        bus.lane_clr  = '0;
        #1;
        check("reset_lane_valid", 32'(bus.lane_valid), 32'h00);
        check("reset_ptr",        32'(bus.ptr),        32'h0);
        check("reset_o7",         32'(bus.o7),         32'h0);
        #20 rst_n = 1'b1;

        // Auto frame 1..8
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 3'd0, 4'(i + 1), 8'h00, 1'b0);
            check($sformatf("auto_o%0d", i), 32'(o_arr[i]), 32'(i + 1));
            check($sformatf("auto_overrun_%0d", i), 32'(bus.overrun), 32'h0);
            check($sformatf("auto_frame_done_%0d", i), 32'(bus.frame_done), (i == 7) ? 32'h1 : 32'h0);
        end
        check("auto_ptr_wrap",   32'(bus.ptr),        32'h0);
        check("auto_lane_valid", 32'(bus.lane_valid), 32'hFF);
        idle(8'h00, 1'b0);
        check("auto_frame_done_drop", 32'(bus.frame_done), 32'h0);

        // Overwrite while full: overrun, but no new frame_done
        wr(1'b1, 3'd0, 4'h9, 8'h00, 1'b0);
        check("full_ovw_o0",         32'(bus.o0),         32'h9);
        check("full_ovw_overrun",    32'(bus.overrun),    32'h1);
        check("full_ovw_frame_done", 32'(bus.frame_done), 32'h0);
        check("full_ovw_ptr",        32'(bus.ptr),        32'h1);

        idle(8'h00, 1'b1);
        check("clear_lane_valid", 32'(bus.lane_valid), 32'h00);
        check("clear_ptr",        32'(bus.ptr),        32'h0);
        check("clear_keeps_o0",   32'(bus.o0),         32'h9);

        // Manual writes and overrun
        wr(1'b0, 3'd5, 4'hA, 8'h00, 1'b0);
        check("man_o5_a",       32'(bus.o5),         32'hA);
        check("man_lane_valid", 32'(bus.lane_valid), 32'h20);
        check("man_overrun_0",  32'(bus.overrun),    32'h0);
        check("man_ptr_hold",   32'(bus.ptr),        32'h0);
        wr(1'b0, 3'd5, 4'hB, 8'h00, 1'b0);
        check("man_o5_b",       32'(bus.o5),      32'hB);
        check("man_overrun_1",  32'(bus.overrun), 32'h1);
        idle(8'h00, 1'b0);
        check("man_overrun_end", 32'(bus.overrun), 32'h0);

        // Write/consume collision on lane 2
        wr(1'b0, 3'd2, 4'h3, 8'h00, 1'b0);
        check("col_lv_set", 32'(bus.lane_valid), 32'h24);
        wr(1'b0, 3'd2, 4'h4, 8'h04, 1'b0);
        check("col_lv_hold",  32'(bus.lane_valid), 32'h24);
        check("col_overrun",  32'(bus.overrun),    32'h0);
        check("col_o2",       32'(bus.o2),         32'h4);
        idle(8'h04, 1'b0);
        check("consume_lv",   32'(bus.lane_valid), 32'h20);
        check("consume_o2",   32'(bus.o2),         32'h4);

        // Clear priority over a same-cycle write
        idle(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) wr(1'b1, 3'd0, 4'hE, 8'h00, 1'b0);
        check("pre_clr_ptr", 32'(bus.ptr),        32'h3);
        check("pre_clr_lv",  32'(bus.lane_valid), 32'h07);
        wr(1'b1, 3'd0, 4'hF, 8'h00, 1'b1);
        check("clrw_o3",         32'(bus.o3),         32'h4);
        check("clrw_ptr",        32'(bus.ptr),        32'h0);
        check("clrw_lv",         32'(bus.lane_valid), 32'h00);
        check("clrw_overrun",    32'(bus.overrun),    32'h0);
        check("clrw_frame_done", 32'(bus.frame_done), 32'h0);

        // Mode switch keeps ptr
        wr(1'b1, 3'd0, 4'h1, 8'h00, 1'b0);
        wr(1'b1, 3'd0, 4'h2, 8'h00, 1'b0);
        check("ms_ptr2", 32'(bus.ptr), 32'h2);
        wr(1'b0, 3'd6, 4'hC, 8'h00, 1'b0);
        check("ms_o6",      32'(bus.o6),  32'hC);
        check("ms_ptr_hold", 32'(bus.ptr), 32'h2);
        wr(1'b1, 3'd6, 4'hD, 8'h00, 1'b0);
        check("ms_o2",   32'(bus.o2),  32'hD);
        check("ms_ptr3", 32'(bus.ptr), 32'h3);

        // Reset mid-frame, asynchronously between edges
        idle(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) wr(1'b1, 3'd0, 4'h7, 8'h00, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_o0",  32'(bus.o0),         32'h0);
        check("rst_mid_o6",  32'(bus.o6),         32'h0);
        check("rst_mid_lv",  32'(bus.lane_valid), 32'h00);
        check("rst_mid_ptr", 32'(bus.ptr),        32'h0);
        check("rst_mid_ovr", 32'(bus.overrun),    32'h0);
        check("rst_mid_fd",  32'(bus.frame_done), 32'h0);
        #12 rst_n = 1'b1;
        step();
        check("post_rst_o1", 32'(bus.o1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
